// File: rtl/mem_pkg.sv
// mem_pkg: shared cache-line / burst-beat geometry used by the arbiter and burst adapter.
//   LINE_W      cache line width in bits
//   BEAT_W      burst beat width in bits
//   BEATS       beats per line
//   LINE_OFF_W  byte-offset bits within a line (forced to zero on burst addresses)
package mem_pkg;

    localparam int LINE_W     = 256;
    localparam int BEAT_W     = 64;
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int BEAT_IDX_W = $clog2(BEATS);
    localparam int LINE_OFF_W = $clog2(LINE_W / 8);

    typedef logic [LINE_W-1:0]     line_t;
    typedef logic [BEAT_W-1:0]     beat_t;
    typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

    // Beat 0 is the least significant slice of the line.
    function automatic beat_t get_beat(input line_t l, input beat_idx_t i);
        return l[int'(i)*BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/burst_adapter.sv
// burst_adapter: turns single-cycle cache-line requests into 64-bit memory bursts and reassembles read lines.
//   clk, rst          clock, synchronous active-high reset
//   arb_addr          line address from arbiter (sampled with arb_read / arb_write)
//   arb_read          one-cycle read-line request
//   arb_write         one-cycle write-line request
//   arb_wdata         write line (sampled with arb_write)
//   arb_rdata         assembled read line, meaningful with arb_rvalid
//   arb_rvalid        one-cycle pulse: read line complete
//   arb_wdone         one-cycle pulse: all write beats accepted
//   busy              high from request capture through the response cycle
//   bmem_addr         line-aligned burst address
//   bmem_read         read command, held until bmem_ready
//   bmem_write        write beat valid
//   bmem_wdata        write beat data
//   bmem_ready        memory accepts command / beat
//   bmem_raddr        address tag of returning read beat
//   bmem_rdata        returning read beat data
//   bmem_rvalid       returning read beat valid
module burst_adapter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] arb_addr,
    input  logic              arb_read,
    input  logic              arb_write,
    input  line_t             arb_wdata,
    output line_t             arb_rdata,
    output logic              arb_rvalid,
    output logic              arb_wdone,
    output logic              busy,
    output logic [ADDR_W-1:0] bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output beat_t             bmem_wdata,
    input  logic              bmem_ready,
    input  logic [ADDR_W-1:0] bmem_raddr,
    input  beat_t             bmem_rdata,
    input  logic              bmem_rvalid
);

    typedef enum logic [2:0] {IDLE, RD_CMD, RD_COLLECT, WR_BEAT, RESP} state_t;

    localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS - 1);

    state_t            state;
    beat_idx_t         beat;
    line_t             line_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] line_addr;

    assign line_addr = arb_addr & ~ADDR_W'(LINE_W / 8 - 1);
    // The line register doubles as write buffer and read assembly buffer.
    assign arb_rdata = line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            line_q     <= '0;
            addr_q     <= '0;
            arb_rvalid <= 1'b0;
            arb_wdone  <= 1'b0;
            busy       <= 1'b0;
            bmem_addr  <= '0;
            bmem_read  <= 1'b0;
            bmem_write <= 1'b0;
            bmem_wdata <= '0;
        end else begin
            arb_rvalid <= 1'b0;
            arb_wdone  <= 1'b0;
            case (state)
                IDLE: begin
                    // Write takes priority when both pulses arrive together.
                    if (arb_write) begin
                        state      <= WR_BEAT;
                        beat       <= '0;
                        addr_q     <= line_addr;
                        line_q     <= arb_wdata;
                        busy       <= 1'b1;
                        bmem_addr  <= line_addr;
                        bmem_write <= 1'b1;
                        bmem_wdata <= get_beat(arb_wdata, '0);
                    end else if (arb_read) begin
                        state     <= RD_CMD;
                        beat      <= '0;
                        addr_q    <= line_addr;
                        busy      <= 1'b1;
                        bmem_addr <= line_addr;
                        bmem_read <= 1'b1;
                    end
                end
                RD_CMD: begin
                    if (bmem_ready) begin
                        state     <= RD_COLLECT;
                        bmem_read <= 1'b0;
                    end
                end
                RD_COLLECT: begin
                    // Beats tagged for another line are ignored.
                    if (bmem_rvalid && bmem_raddr == addr_q) begin
                        line_q[int'(beat)*BEAT_W +: BEAT_W] <= bmem_rdata;
                        if (beat == LAST_BEAT) begin
                            state      <= RESP;
                            arb_rvalid <= 1'b1;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                WR_BEAT: begin
                    if (bmem_ready) begin
                        if (beat == LAST_BEAT) begin
                            state      <= RESP;
                            bmem_write <= 1'b0;
                            arb_wdone  <= 1'b1;
                        end else begin
                            beat       <= beat + 1'b1;
                            bmem_wdata <= get_beat(line_q, beat + 1'b1);
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Upstream protocol checks: requests are legal only one at a time and only while idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(state == IDLE && arb_read && arb_write))
                else $warning("burst_adapter: read and write requested together, read dropped");
            assert (state == IDLE || !(arb_read || arb_write))
                else $warning("burst_adapter: request while busy ignored");
        end
    end

endmodule

// File: tb/tb_burst_adapter.sv
// tb_burst_adapter: directed self-checking bench for burst_adapter.
module tb_burst_adapter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] arb_addr;
    logic        arb_read;
    logic        arb_write;
    line_t       arb_wdata;
    line_t       arb_rdata;
    logic        arb_rvalid;
    logic        arb_wdone;
    logic        busy;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    beat_t       bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    beat_t       bmem_rdata;
    logic        bmem_rvalid;

    int errors = 0;
    int checks = 0;

    burst_adapter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .arb_addr(arb_addr), .arb_read(arb_read), .arb_write(arb_write), .arb_wdata(arb_wdata),
        .arb_rdata(arb_rdata), .arb_rvalid(arb_rvalid), .arb_wdone(arb_wdone), .busy(busy),
        .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
        .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input line_t d);
        arb_read  = rd;
        arb_write = wr;
        arb_addr  = a;
        arb_wdata = d;
        tick();
        arb_read  = 1'b0;
        arb_write = 1'b0;
    endtask

    task automatic beat_in(input logic [31:0] a, input beat_t d);
        bmem_rvalid = 1'b1;
        bmem_raddr  = a;
        bmem_rdata  = d;
        tick();
        bmem_rvalid = 1'b0;
    endtask

    beat_t wb [4] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                      64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};
    beat_t wb2 [4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
                       64'h5555_6666_7777_8888, 64'h9999_0000_FEDC_BA98};
    beat_t rb [4] = '{64'h0, 64'h1111_1111_1111_1111,
                      64'h2222_2222_2222_2222, 64'h3333_3333_3333_3333};
    beat_t rb2 [4] = '{64'hCAFE_0000_0000_0000, 64'hCAFE_0000_0000_0001,
                       64'hCAFE_0000_0000_0002, 64'hCAFE_0000_0000_0003};

    initial begin
        rst = 1'b1;
        arb_addr = '0; arb_read = 1'b0; arb_write = 1'b0; arb_wdata = '0;
        bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
        tick();
        tick();
        check("rst_rvalid", arb_rvalid, 0);
        check("rst_wdone", arb_wdone, 0);
        check("rst_busy", busy, 0);
        check("rst_bread", bmem_read, 0);
        check("rst_bwrite", bmem_write, 0);
        check("rst_baddr", bmem_addr, 0);
        check("rst_bwdata", bmem_wdata, 0);
        check("rst_rdata", arb_rdata, 0);
        rst = 1'b0;
        tick();

        // Plain write, memory always ready.
        req(1'b0, 1'b1, 32'h0000_1020, {wb[3], wb[2], wb[1], wb[0]});
        check("w1_busy", busy, 1);
        check("w1_addr", bmem_addr, 32'h0000_1020);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("w1_write%0d", k), bmem_write, 1);
            check($sformatf("w1_data%0d", k), bmem_wdata, wb[k]);
            check($sformatf("w1_nodone%0d", k), arb_wdone, 0);
            tick();
        end
        check("w1_wdone", arb_wdone, 1);
        check("w1_write_off", bmem_write, 0);
        check("w1_busy_resp", busy, 1);
        tick();
        check("w1_wdone_pulse", arb_wdone, 0);
        check("w1_busy_off", busy, 0);
        tick();

        // Write with three stall cycles on beat 2.
        req(1'b0, 1'b1, 32'h0000_2047, {wb2[3], wb2[2], wb2[1], wb2[0]});
        check("w2_addr", bmem_addr, 32'h0000_2040);
        check("w2_data0", bmem_wdata, wb2[0]);
        tick();
        check("w2_data1", bmem_wdata, wb2[1]);
        tick();
        bmem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("w2_hold_data%0d", k), bmem_wdata, wb2[2]);
            check($sformatf("w2_hold_addr%0d", k), bmem_addr, 32'h0000_2040);
            check($sformatf("w2_hold_nodone%0d", k), arb_wdone, 0);
            tick();
        end
        bmem_ready = 1'b1;
        check("w2_data2", bmem_wdata, wb2[2]);
        tick();
        check("w2_data3", bmem_wdata, wb2[3]);
        tick();
        check("w2_wdone", arb_wdone, 1);
        tick();

        // Plain read with back-to-back beats.
        req(1'b1, 1'b0, 32'h1ECE_B014, '0);
        check("r1_bread", bmem_read, 1);
        check("r1_addr", bmem_addr, 32'h1ECE_B000);
        check("r1_nowrite", bmem_write, 0);
        check("r1_busy", busy, 1);
        tick();
        check("r1_bread_off", bmem_read, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("r1_norvalid%0d", k), arb_rvalid, 0);
            beat_in(32'h1ECE_B000, rb[k]);
        end
        check("r1_rvalid", arb_rvalid, 1);
        check("r1_rdata", arb_rdata, {rb[3], rb[2], rb[1], rb[0]});
        tick();
        check("r1_rvalid_pulse", arb_rvalid, 0);
        check("r1_busy_off", busy, 0);
        check("r1_rdata_held", arb_rdata, {rb[3], rb[2], rb[1], rb[0]});

        // Read with gaps and stray beats for another line.
        req(1'b1, 1'b0, 32'h0000_0080, '0);
        tick();
        beat_in(32'h0000_0080, rb2[0]);
        tick();
        tick();
        beat_in(32'h0000_0040, 64'hDEAD_BEEF_DEAD_BEEF);
        beat_in(32'h0000_0080, rb2[1]);
        tick();
        tick();
        beat_in(32'h0000_0080, rb2[2]);
        beat_in(32'h0000_0040, 64'hBAD0_BAD0_BAD0_BAD0);
        check("r2_norvalid", arb_rvalid, 0);
        beat_in(32'h0000_0080, rb2[3]);
        check("r2_rvalid", arb_rvalid, 1);
        check("r2_rdata", arb_rdata, {rb2[3], rb2[2], rb2[1], rb2[0]});
        tick();

        // Simultaneous read and write: the write wins.
        req(1'b1, 1'b1, 32'h0000_3000, {wb[3], wb[2], wb[1], wb[0]});
        check("rw_addr", bmem_addr, 32'h0000_3000);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rw_noread%0d", k), bmem_read, 0);
            check($sformatf("rw_data%0d", k), bmem_wdata, wb[k]);
            tick();
        end
        check("rw_wdone", arb_wdone, 1);
        check("rw_norvalid", arb_rvalid, 0);
        tick();

        // Reset in the middle of a read, then a clean read.
        req(1'b1, 1'b0, 32'h0000_4000, '0);
        tick();
        beat_in(32'h0000_4000, 64'h7777_7777_7777_7777);
        beat_in(32'h0000_4000, 64'h8888_8888_8888_8888);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_busy", busy, 0);
        check("mr_bread", bmem_read, 0);
        check("mr_rvalid", arb_rvalid, 0);
        check("mr_rdata", arb_rdata, 0);
        beat_in(32'h0000_4000, 64'h9999_9999_9999_9999);
        beat_in(32'h0000_4000, 64'hAAAA_AAAA_AAAA_AAAA);
        check("mr_idle_rvalid", arb_rvalid, 0);
        check("mr_idle_busy", busy, 0);
        req(1'b1, 1'b0, 32'h0000_5010, '0);
        check("mr2_addr", bmem_addr, 32'h0000_5000);
        tick();
        for (int k = 0; k < 4; k++) beat_in(32'h0000_5000, rb[k]);
        check("mr2_rvalid", arb_rvalid, 1);
        check("mr2_rdata", arb_rdata, {rb[3], rb[2], rb[1], rb[0]});
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
